// File: rtl/uart_sys_pkg.sv
// Shared definitions for the UART command path: command codes and the
// decoder state encoding used by the receive and transmit side blocks.
package uart_sys_pkg;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

endpackage

// File: rtl/frame_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count sits at timeout-1.
module frame_timeout_timer #(
  parameter logic [15:0] timeout = 16'd5000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [15:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (clr || !en) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Combinational so the FSM can abort in the same cycle the limit is hit.
  assign tc = en && (cnt == timeout - 16'd1);

endmodule

// File: rtl/rx_cmd_decoder.sv
// Assembles AA/BB command frames from received bytes, issues register
// write/read strobes and forwards read data to the UART transmitter.
module rx_cmd_decoder
  import uart_sys_pkg::*;
#(
  parameter int          width   = 8,
  parameter int          addr_w  = 4,
  parameter logic [15:0] timeout = 16'd5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [width-1:0]  rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic              rd_en,
  output logic [addr_w-1:0] addr,
  output logic [width-1:0]  wr_data,
  input  logic [width-1:0]  rd_data,
  input  logic              rd_data_valid,
  output logic [width-1:0]  tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic              frame_err
);

  state_t             state_q, state_d;
  logic               wr_en_d, rd_en_d, tx_valid_d, frame_err_d;
  logic [addr_w-1:0]  addr_d;
  logic [width-1:0]   wr_data_d, tx_data_d, rd_buf, rd_buf_d;
  logic               tmr_en, tmr_clr, tmr_tc;

  assign tmr_en  = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                   (state_q == RD_ADDR) || (state_q == RD_WAIT);
  assign tmr_clr = rx_valid || (state_d != state_q);

  frame_timeout_timer #(.timeout(timeout)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      tx_valid  <= 1'b0;
      frame_err <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      tx_data   <= '0;
      rd_buf    <= '0;
    end else begin
      state_q   <= state_d;
      wr_en     <= wr_en_d;
      rd_en     <= rd_en_d;
      tx_valid  <= tx_valid_d;
      frame_err <= frame_err_d;
      addr      <= addr_d;
      wr_data   <= wr_data_d;
      tx_data   <= tx_data_d;
      rd_buf    <= rd_buf_d;
    end
  end

  // A received byte always takes priority over a same-cycle timeout.
  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    tx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    addr_d      = addr;
    wr_data_d   = wr_data;
    tx_data_d   = tx_data;
    rd_buf_d    = rd_buf;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == width'(CMD_WR))      state_d = WR_ADDR;
          else if (rx_data == width'(CMD_RD)) state_d = RD_ADDR;
          else                                frame_err_d = 1'b1;
        end
      end
      WR_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data[addr_w-1:0];
          state_d = WR_DATA;
        end else if (tmr_tc) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      WR_DATA: begin
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          wr_data_d = rx_data;
          state_d   = IDLE;
        end else if (tmr_tc) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data[addr_w-1:0];
          rd_en_d = 1'b1;
          state_d = RD_WAIT;
        end else if (tmr_tc) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      RD_WAIT: begin
        if (rx_valid) frame_err_d = 1'b1;
        if (rd_data_valid) begin
          rd_buf_d = rd_data;
          state_d  = TX_SEND;
        end else if (tmr_tc && !rx_valid) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      TX_SEND: begin
        if (rx_valid) frame_err_d = 1'b1;
        if (!tx_busy) begin
          tx_valid_d = 1'b1;
          tx_data_d  = rd_buf;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Directed bench for rx_cmd_decoder: write, read, bad command, timeout,
// busy transmitter and mid-frame reset scenarios.
module tb_rx_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       wr_en, rd_en;
  logic [3:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data = 8'h00;
  logic       rd_data_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy = 1'b0;
  logic       frame_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  rx_cmd_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .addr          (addr),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_busy       (tx_busy),
    .frame_err     (frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: one-cycle byte pulse; returns at the negedge where results are visible
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic return_rd(input logic [7:0] d);
    rd_data       = d;
    rd_data_valid = 1'b1;
    @(negedge clk);
    rd_data_valid = 1'b0;
  endtask

  // scoreboard: every transmitted byte must match the next expected one
  always @(negedge clk) begin
    if (!rst && tx_valid) begin
      if (exp_q.size() == 0) chk("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
      else chk("tx_sb", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int first_err;
    int wr_seen;
    int txv_seen;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_addr", addr, 0);
    chk("rst_tx_data", tx_data, 0);
    rst = 1'b0;

    // write frame AA 05 3C
    send_byte(8'hAA);
    send_byte(8'h05);
    chk("wr_no_early", wr_en, 0);
    send_byte(8'h3C);
    chk("wr_en", wr_en, 1);
    chk("wr_addr", addr, 5);
    chk("wr_data", wr_data, 8'h3C);
    chk("wr_no_err", frame_err, 0);
    @(negedge clk);
    chk("wr_en_single", wr_en, 0);

    // read frame BB 0A, data 7E three cycles after rd_en
    send_byte(8'hBB);
    send_byte(8'h0A);
    chk("rd_en", rd_en, 1);
    chk("rd_addr", addr, 4'hA);
    repeat (3) @(negedge clk);
    chk("rd_en_single", rd_en, 0);
    exp_q.push_back(8'h7E);
    return_rd(8'h7E);
    chk("rd_tx_not_yet", tx_valid, 0);
    @(negedge clk);
    chk("rd_tx_valid", tx_valid, 1);
    chk("rd_tx_data", tx_data, 8'h7E);

    // unknown command, then a normal write
    send_byte(8'h55);
    chk("bad_err", frame_err, 1);
    chk("bad_no_wr", wr_en, 0);
    chk("bad_no_rd", rd_en, 0);
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'hFF);
    chk("rec_wr_en", wr_en, 1);
    chk("rec_addr", addr, 1);
    chk("rec_data", wr_data, 8'hFF);

    // timeout after AA 02: counter 0 in the first WR_DATA cycle, error 5000 cycles later
    send_byte(8'hAA);
    send_byte(8'h02);
    first_err = -1;
    wr_seen   = 0;
    for (int i = 0; i < 6000; i++) begin
      if (frame_err && first_err < 0) first_err = i;
      if (wr_en) wr_seen++;
      if (first_err >= 0 && i > first_err + 2) break;
      @(negedge clk);
    end
    chk("to_cycle", first_err, 5000);
    chk("to_no_wr", wr_seen, 0);
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h44);
    chk("to_next_wr", wr_en, 1);
    chk("to_next_addr", addr, 3);
    chk("to_next_data", wr_data, 8'h44);

    // busy transmitter with a stray byte while waiting
    tx_busy = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h07);
    chk("busy_rd_en", rd_en, 1);
    exp_q.push_back(8'h5A);
    return_rd(8'h5A);
    txv_seen = 0;
    repeat (20) begin
      if (tx_valid) txv_seen++;
      @(negedge clk);
    end
    send_byte(8'h11);
    chk("busy_drop_err", frame_err, 1);
    repeat (25) begin
      if (tx_valid) txv_seen++;
      @(negedge clk);
    end
    chk("busy_no_tx", txv_seen, 0);
    chk("busy_tx_hold", tx_data, 8'h7E);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("busy_tx_valid", tx_valid, 1);
    chk("busy_tx_data", tx_data, 8'h5A);
    @(negedge clk);
    chk("busy_tx_single", tx_valid, 0);

    // asynchronous reset mid-frame
    send_byte(8'hAA);
    send_byte(8'h04);
    chk("pre_rst_addr", addr, 4);
    #1 rst = 1'b1;
    #1;
    chk("arst_addr", addr, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h05);
    chk("post_rst_err1", frame_err, 1);
    chk("post_rst_no_wr1", wr_en, 0);
    send_byte(8'h06);
    chk("post_rst_err2", frame_err, 1);
    chk("post_rst_no_wr2", wr_en, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_cmd_decoder.md
# rx_cmd_decoder

Command-frame decoder sitting directly downstream of the UART receiver. It consumes the receiver's parallel byte and one-cycle valid pulse and assembles multi-byte command frames. It issues register-file write/read requests and returns read data to the UART transmitter through a valid/busy handshake. Malformed or stalled frames are aborted with an error pulse so the link always recovers to idle.

## Interface
- `width`, 8, data byte width; must match the receiver's data width.
- `addr_w`, 4, register address width; taken from the low bits of the address byte.
- `timeout`, 16'd5000, maximum clk cycles allowed between bytes of one frame, and from read request to read data.
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  width  received byte; sampled only when `rx_valid` = 1.
- `rx_valid`  in  1  one-cycle pulse per received byte, driven by the receiver's data-valid output.
- `wr_en`  out  1  one-cycle register-write strobe.
- `rd_en`  out  1  one-cycle register-read strobe.
- `addr`  out  addr_w  register address; valid while `wr_en` or `rd_en` = 1, then held.
- `wr_data`  out  width  write data; valid with `wr_en`.
- `rd_data`  in  width  register read data; sampled when `rd_data_valid` = 1.
- `rd_data_valid`  in  1  read-data qualifier, any latency ≥ 1 cycle after `rd_en`.
- `tx_data`  out  width  byte to transmit; held stable from the `tx_valid` pulse until the next `tx_valid`.
- `tx_valid`  out  1  one-cycle transmit request.
- `tx_busy`  in  1  transmitter busy; `tx_valid` is issued only while it is 0.
- `frame_err`  out  1  one-cycle pulse on unknown command, timeout, or a byte received while busy.

## Operation
- Command codes: 0xAA = write (frame: AA, addr, data); 0xBB = read (frame: BB, addr).
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE:
  - byte 0xAA → WR_ADDR.
  - byte 0xBB → RD_ADDR.
  - any other byte → `frame_err` pulse, stay in IDLE.
- WR_ADDR: on a byte, latch `addr` ← byte[addr_w-1:0], go to WR_DATA.
- WR_DATA: on a byte, pulse `wr_en` with `wr_data` = byte, return to IDLE.
- RD_ADDR: on a byte, latch `addr` and pulse `rd_en`, go to RD_WAIT.
- RD_WAIT: on `rd_data_valid`, latch the read data, go to TX_SEND.
- TX_SEND: when `tx_busy` = 0, pulse `tx_valid` with `tx_data` = latched data, return to IDLE.
- Timeout counter:
  - Runs in WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT; clears on every state change and every accepted byte.
  - Reaching `timeout`-1 → `frame_err` pulse, go to IDLE, no strobe issued.
  - Does not run in TX_SEND; the block waits indefinitely for the transmitter.
- A byte arriving in RD_WAIT or TX_SEND is dropped and pulses `frame_err`; the state is unchanged.
- `rx_valid` and timeout expiry in the same cycle: the byte wins and the counter clears.
- `rd_data_valid` outside RD_WAIT is ignored.
- Reset (asynchronous, at any time, including mid-frame):
  - state → IDLE.
  - all strobes, `frame_err`, `addr`, `wr_data`, `tx_data` and the counter → 0.

## Timing
- All outputs are registered.
- Byte accepted in cycle n → resulting `wr_en` / `rd_en` / `frame_err` asserted in cycle n+1 for exactly one cycle.
- `rd_data_valid` in cycle n → `tx_valid` in cycle n+2 at the earliest (n+1 enters TX_SEND, n+2 issues if `tx_busy` = 0).
- Back-to-back frames: a new command byte may arrive the cycle after `wr_en`; no dead cycle.

## Structure
- Package `uart_sys_pkg`: command codes (CMD_WR = 8'hAA, CMD_RD = 8'hBB) and the state enum; shared with the transmitter-side blocks.
- Sub-module `frame_timeout_timer`: clear/enable inputs, terminal-count pulse output, `timeout` parameter.
- The FSM and output registers live in `rx_cmd_decoder`.

## Test plan
- Write frame: bytes AA, 05, 3C → single `wr_en` pulse with `addr` = 5, `wr_data` = 0x3C, 1 cycle after the third byte; `frame_err` = 0.
- Read frame: bytes BB, 0A; `rd_data` = 0x7E returned 3 cycles after `rd_en`, `tx_busy` = 0 → `rd_en` with `addr` = 0xA, then `tx_valid` with `tx_data` = 0x7E 2 cycles after `rd_data_valid`.
- Unknown command 0x55 → `frame_err` pulse, no strobes; a following AA, 01, FF frame completes normally.
- Timeout: bytes AA, 02, then silence for `timeout` cycles → `frame_err` pulse, no `wr_en`; the next byte is decoded as a command.
- Busy transmitter: read completes while `tx_busy` = 1 for 50 cycles; a byte 0x11 arrives meanwhile → `frame_err` pulse, byte dropped; `tx_valid` issued the first cycle `tx_busy` = 0.
- Reset asserted after AA, 04 → all outputs 0 immediately; after release, bytes 05, 06 produce two `frame_err` pulses and no `wr_en`.
